tmul_tile_loader: RTL and testbench
===================================

TMUL_TILE_LOADER -- requirements
Module: tmul_tile_loader

Interface
REQ-001 SHALL have parameter N, default 8, meaning vector length and matrix dimension.
REQ-002 SHALL have parameter W, default 32, meaning operand width; result width is 2W.
REQ-003 SHALL have parameter LAT, default 2, legal range 1..15, meaning cycles from operand-stable to c_in valid.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, meaning an asynchronous, active-low reset.
REQ-006 SHALL have port s_data, input, W, meaning the operand stream word.
REQ-007 SHALL have port s_valid, input, 1, meaning s_data is valid.
REQ-008 SHALL have port s_ready, output, 1, meaning the loader accepts a word; a beat is s_valid&s_ready.
REQ-009 SHALL have port s_last, input, 1, meaning the final word of a tile.
REQ-010 SHALL have port a_out, output, N*W, meaning vector a; lane j is a_out[j*W +: W].
REQ-011 SHALL have port b_out, output, N*N*W, meaning matrix b; row j occupies [j*N*W +: N*W], and element k of that row sits at offset k*W.
REQ-012 SHALL have port c_in, input, N*2W, meaning TMUL results; lane j is c_in[j*2W +: 2W].
REQ-013 SHALL have ports m_data (output, 2W), m_valid (output, 1), m_ready (input, 1) and m_last (output, 1), meaning the result stream.
REQ-014 SHALL have port busy, output, 1, meaning a tile is in WAIT or DRAIN.
REQ-015 SHALL have port err_len, output, 1, meaning a one-cycle pulse on a tile-length error.

Function
REQ-016 SHALL implement the states LOAD_A, LOAD_B, WAIT and DRAIN.
REQ-017 SHALL accept one tile of N+N*N words (72 at defaults) in this order: a[0..N-1], then b[j][k] row-major with j outer.
REQ-018 SHALL, on each accepted beat, write the addressed word into a_out/b_out at the next edge, leaving all other lanes unchanged.
REQ-019 SHALL drive s_ready=1 only in LOAD_A and LOAD_B.
REQ-020 SHALL move from LOAD_A to LOAD_B after beat N, and to WAIT after the beat that carries s_last on word index N+N*N-1.
REQ-021 SHALL treat s_last on any earlier beat as an error: pulse err_len, discard the tile, return to LOAD_A, and clear the word counter.
REQ-022 SHALL treat a final beat without s_last as the same error as REQ-021.
REQ-023 SHALL hold a_out/b_out stable from the final beat until the next tile's first beat.
REQ-024 SHALL, in WAIT, sample all of c_in into the result buffer on the LAT-th rising edge after the edge that accepted the final beat, then enter DRAIN.
REQ-025 SHALL, in DRAIN, present lanes 0..N-1 in order, with m_valid high from the cycle after capture.
REQ-026 SHALL hold m_data constant while m_valid=1 and m_ready=0.
REQ-027 SHALL assert m_last with lane N-1 only.
REQ-028 SHALL return to LOAD_A after the lane N-1 handshake, so that s_ready=1 on the following cycle.
REQ-029 SHALL never overlap load and drain.
REQ-030 SHALL keep busy=1 exactly in WAIT and DRAIN.

Reset
REQ-031 SHALL, while rst=0, asynchronously force: state LOAD_A, counters 0, a_out/b_out/result buffer 0, s_ready 0, m_valid 0, m_data 0, m_last 0, busy 0, err_len 0.
REQ-032 SHALL drive s_ready=1 from the first edge after rst deasserts.
REQ-033 SHALL, on reset mid-tile or mid-drain, abandon the tile with no further m_valid beats.

Structure
REQ-034 SHALL take N, W, TILE_WORDS=N+N*N and the state enum from a shared package tmul_pkg.
REQ-035 SHALL place the capture buffer and 2W serializer (REQ-024..027) in the sub-module tmul_result_drain.

Verification
REQ-036 SHALL cover: a[j]=j+1, b[j][k]=k+1, s_valid continuous -> a_out lane 3=4, b_out row 5 element 2=3, s_ready=0 the cycle after beat 72, busy=1.
REQ-037 SHALL cover: c_in lane j=j*1000, m_ready=1, LAT=2 -> capture 2 edges after the final beat, beats 0,1000..7000 on 8 consecutive cycles, m_last on 7000, s_ready=1 the next cycle.
REQ-038 SHALL cover: m_ready alternating 1,0 -> each lane appears exactly once, m_data stable during stalls, 15 cycles to drain.
REQ-039 SHALL cover: s_last on beat 10 -> err_len high one cycle, then a 72-beat tile loads and drains correctly.
REQ-040 SHALL cover: s_valid asserted on every other cycle -> outputs identical to REQ-036.
REQ-041 SHALL cover: rst=0 after 3 drain beats -> m_valid=0 immediately, a_out=0, s_ready=1 one edge after release.

Source files
------------

// File: rtl/tmul_pkg.sv
// Shared sizing defaults, tile geometry and loader state encoding for the TMUL tile loader.
package tmul_pkg;

  localparam int TMUL_N     = 8;
  localparam int TMUL_W     = 32;
  localparam int TILE_WORDS = TMUL_N + TMUL_N * TMUL_N;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DRAIN  = 2'd3
  } tmul_state_e;

  function automatic int tile_words(input int n);
    return n + n * n;
  endfunction

endpackage

// File: rtl/tmul_result_drain.sv
// Captures one row of TMUL results and serializes it lane by lane onto a valid/ready stream.
module tmul_result_drain
  import tmul_pkg::*;
#(
  parameter int N = TMUL_N,
  parameter int W = TMUL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cap_i,
  input  logic [N*2*W-1:0]   c_in,
  output logic [2*W-1:0]     m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic               done_o
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0][2*W-1:0] res_q;
  logic [LW-1:0]         lane_q;
  logic                  vld_q;

  assign m_valid = vld_q;
  assign m_last  = vld_q && (lane_q == LW'(N - 1));
  assign done_o  = m_last && m_ready;
  // Gated so the stream reads zero whenever nothing is being offered.
  assign m_data  = vld_q ? res_q[lane_q] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_q  <= '0;
      lane_q <= '0;
      vld_q  <= 1'b0;
    end else if (cap_i) begin
      res_q  <= c_in;
      lane_q <= '0;
      vld_q  <= 1'b1;
    end else if (vld_q && m_ready) begin
      if (lane_q == LW'(N - 1)) vld_q  <= 1'b0;
      else                      lane_q <= lane_q + LW'(1);
    end
  end

endmodule

// File: rtl/tmul_tile_loader.sv
// Loads an a-vector plus b-matrix tile from a word stream, waits LAT cycles for the
// TMUL array, then drains its N results; load and drain never overlap.
module tmul_tile_loader
  import tmul_pkg::*;
#(
  parameter int N   = TMUL_N,
  parameter int W   = TMUL_W,
  parameter int LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W-1:0]         s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic                 s_last,
  output logic [N*W-1:0]       a_out,
  output logic [N*N*W-1:0]     b_out,
  input  logic [N*2*W-1:0]     c_in,
  output logic [2*W-1:0]       m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err_len
);

  localparam int TW = tile_words(N);
  localparam int CW = $clog2(TW);

  tmul_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 err_q, err_d;
  logic                 live_q;
  logic [N-1:0][W-1:0]  a_q;
  logic [N*N-1:0][W-1:0] b_q;
  logic                 beat, cap, done;

  // live_q keeps s_ready low while in reset and raises it on the first edge after release.
  assign s_ready = live_q && (state_q == ST_LOAD_A || state_q == ST_LOAD_B);
  assign beat    = s_valid && s_ready;
  assign cap     = (state_q == ST_WAIT) && (wcnt_q == 4'(LAT));
  assign busy    = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign err_len = err_q;
  assign a_out   = a_q;
  assign b_out   = b_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    err_d   = 1'b0;
    case (state_q)
      ST_LOAD_A, ST_LOAD_B: begin
        if (beat) begin
          if (cnt_q == CW'(TW - 1)) begin
            cnt_d = '0;
            if (s_last) begin
              state_d = ST_WAIT;
              wcnt_d  = 4'd1;
            end else begin
              state_d = ST_LOAD_A;
              err_d   = 1'b1;
            end
          end else if (s_last) begin
            state_d = ST_LOAD_A;
            cnt_d   = '0;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(N - 1)) state_d = ST_LOAD_B;
          end
        end
      end
      // wcnt_q counts edges since the final beat; capture happens on edge LAT.
      ST_WAIT:  if (cap) state_d = ST_DRAIN; else wcnt_d = wcnt_q + 4'd1;
      ST_DRAIN: if (done) state_d = ST_LOAD_A;
      default:  state_d = ST_LOAD_A;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      err_q   <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      live_q  <= 1'b1;
    end
  end

  // Word index selects the lane: 0..N-1 fill a, the rest fill b row-major.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (beat) begin
      for (int j = 0; j < N; j++)
        if (cnt_q == CW'(j)) a_q[j] <= s_data;
      for (int i = 0; i < N * N; i++)
        if (cnt_q == CW'(N + i)) b_q[i] <= s_data;
    end
  end

  tmul_result_drain #(.N(N), .W(W)) u_drain (
    .clk     (clk),
    .rst     (rst),
    .cap_i   (cap),
    .c_in    (c_in),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .done_o  (done)
  );

endmodule

// File: tb/tb_tmul_tile_loader.sv
// Randomized bench for the tile loader against a tile-level reference model.
module tb_tmul_tile_loader;
  localparam int N   = 8;
  localparam int W   = 32;
  localparam int LAT = 2;
  localparam int TW  = N + N * N;
  localparam int NCV = 16;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [W-1:0]       s_data = '0;
  logic               s_valid = 1'b0;
  logic               s_last = 1'b0;
  logic               s_ready;
  logic [N*W-1:0]     a_out;
  logic [N*N*W-1:0]   b_out;
  logic [N*2*W-1:0]   c_in = '0;
  logic [2*W-1:0]     m_data;
  logic               m_valid;
  logic               m_ready = 1'b0;
  logic               m_last;
  logic               busy;
  logic               err_len;

  int n_chk = 0;
  int n_err = 0;

  // Reference tile: a vector, b matrix (index j*N+k) and per-cycle c_in values after the final beat.
  logic [W-1:0]   ta  [N];
  logic [W-1:0]   tbm [N*N];
  logic [2*W-1:0] cv  [NCV][N];

  always #5 clk = ~clk;

  tmul_tile_loader #(.N(N), .W(W), .LAT(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .a_out   (a_out),
    .b_out   (b_out),
    .c_in    (c_in),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .busy    (busy),
    .err_len (err_len)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic fill(input bit directed);
    for (int j = 0; j < N; j++) ta[j] = directed ? W'(j + 1) : W'($urandom);
    for (int i = 0; i < N * N; i++) tbm[i] = directed ? W'((i % N) + 1) : W'($urandom);
    for (int k = 0; k < NCV; k++)
      for (int j = 0; j < N; j++) cv[k][j] = {$urandom, $urandom};
    if (directed)
      for (int j = 0; j < N; j++) cv[LAT-1][j] = 64'(j * 1000);
    for (int j = 0; j < N; j++) c_in[j*2*W +: 2*W] = {$urandom, $urandom};
  endtask

  // gap: 0 continuous, 1 idle cycle before every word, 2 random idles.
  task automatic send_tile(input int nw, input int last_at, input int gap);
    int t;
    for (int i = 0; i < nw; i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 3) == 0)) begin
        s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = (i < N) ? ta[i] : tbm[i-N];
      s_last  = (i == last_at);
      t = 0;
      while (!s_ready && t < 50) begin @(negedge clk); t++; end
      if (!s_ready) begin chk("s_ready_wait", s_ready, 1); break; end
      @(negedge clk);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic check_tile();
    for (int j = 0; j < N; j++) chk("a_lane", a_out[j*W +: W], ta[j]);
    for (int i = 0; i < N * N; i++) chk("b_elem", b_out[i*W +: W], tbm[i]);
  endtask

  // Called at the negedge right after the final beat's edge. mode: 0 ready, 1 alternating, 2 random.
  task automatic run_drain(input int mode, input int maxb, input int exp_cyc);
    logic [2*W-1:0] ex [N];
    int k = 0, first = -1, last_hs = -1, idx = 0;
    for (int j = 0; j < N; j++) ex[j] = cv[LAT-1][j];
    chk("busy_wait", busy, 1);
    chk("rdy_wait", s_ready, 0);
    while (idx < maxb && k < 400) begin
      if (k < NCV)
        for (int j = 0; j < N; j++) c_in[j*2*W +: 2*W] = cv[k][j];
      if (m_valid) begin
        if (first < 0) first = k;
        case (mode)
          0:       m_ready = 1'b1;
          1:       m_ready = ((k - first) % 2 == 0);
          default: m_ready = ($urandom_range(0, 1) == 1);
        endcase
        chk("m_data", m_data, ex[idx]);
        chk("m_last", m_last, idx == N - 1);
        if (m_ready) begin idx++; last_hs = k; end
      end else begin
        m_ready = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    m_ready = 1'b0;
    chk("drain_beats", idx, maxb);
    chk("first_valid", first, LAT);
    if (exp_cyc > 0) chk("drain_cycles", last_hs - first + 1, exp_cyc);
    if (idx == N) begin
      chk("rdy_after", s_ready, 1);
      chk("busy_after", busy, 0);
      chk("mvalid_after", m_valid, 0);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_len, 0);
    for (int j = 0; j < N; j++) chk("rst_a", a_out[j*W +: W], 0);
    chk("rst_b0", b_out[W-1:0], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1 chk("rdy_pre_edge", s_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst", s_ready, 1);

    // Directed tile, continuous stream, always-ready drain.
    fill(1);
    send_tile(TW, TW - 1, 0);
    run_drain(0, N, N);
    check_tile();
    chk("a_lane3", a_out[3*W +: W], 4);
    chk("b_r5_e2", b_out[(5*N+2)*W +: W], 3);

    // Same tile, every-other-cycle stream, alternating drain.
    fill(1);
    send_tile(TW, TW - 1, 1);
    run_drain(1, N, 2 * N - 1);
    check_tile();

    // Early s_last on beat 10, then a clean tile.
    fill(0);
    send_tile(10, 9, 0);
    chk("err_early", err_len, 1);
    chk("err_early_busy", busy, 0);
    chk("err_early_rdy", s_ready, 1);
    @(negedge clk);
    chk("err_early_pulse", err_len, 0);
    fill(0);
    send_tile(TW, TW - 1, 0);
    run_drain(2, N, -1);
    check_tile();

    // Final beat without s_last.
    fill(0);
    send_tile(TW, -1, 0);
    chk("err_nolast", err_len, 1);
    chk("err_nolast_busy", busy, 0);
    @(negedge clk);
    chk("err_nolast_pulse", err_len, 0);
    fill(0);
    send_tile(TW, TW - 1, 2);
    run_drain(2, N, -1);
    check_tile();

    // Random tiles.
    for (int r = 0; r < 4; r++) begin
      fill(0);
      send_tile(TW, TW - 1, 2);
      run_drain(2, N, -1);
      check_tile();
    end

    // Reset after three drain beats.
    fill(0);
    send_tile(TW, TW - 1, 0);
    run_drain(0, 3, -1);
    rst = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    chk("rst_hold_valid", m_valid, 0);
    rst = 1'b1;
    #1 chk("rdy_pre_edge2", s_ready, 0);
    @(negedge clk);
    chk("rdy_after_rst2", s_ready, 1);
    chk("no_resume_valid", m_valid, 0);
    fill(0);
    send_tile(TW, TW - 1, 0);
    run_drain(0, N, N);
    check_tile();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
